// File: rtl/flip_stim_pkg.sv
// flip_stim_pkg: shared types and frame layout for the flip stimulus controller
package flip_stim_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, WAIT, FLIP} state_e;
  localparam int IDX_W = 16;
  localparam int IDX_LSB = 0;
  localparam int VEC_LSB = 16;
endpackage

// File: rtl/flip_stim_ctrl_if.sv
// flip_stim_ctrl_if: frame input and stimulus output bundle
// master drives frame_data/frame_valid and observes dut_inputs/flip_trig/busy/err_index;
// slave is the controller side.
interface flip_stim_ctrl_if #(parameter int NUM_INS = 8, parameter int FRAME_LEN = 24);
  logic [FRAME_LEN-1:0] frame_data;
  logic frame_valid;
  logic [NUM_INS-1:0] dut_inputs;
  logic flip_trig;
  logic busy;
  logic err_index;
  modport master(output frame_data, frame_valid, input dut_inputs, flip_trig, busy, err_index);
  modport slave(input frame_data, frame_valid, output dut_inputs, flip_trig, busy, err_index);
endinterface

// File: rtl/flip_stim_ctrl_period_counter.sv
// period_counter: saturating period counter with terminal count at PERIOD-1
// clk, reset (sync active-low), clear (to 0, wins), enable (count up), tc (count == PERIOD-1).
module period_counter #(parameter int PERIOD = 10000000) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);
  localparam int CW = $clog2(PERIOD);
  logic [CW-1:0] cnt_q, cnt_d;
  assign tc = cnt_q == CW'(PERIOD - 1);
  always_comb cnt_d = clear ? '0 : (enable && !tc) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= !reset ? '0 : cnt_d;
endmodule

// File: rtl/flip_stim_ctrl.sv
// flip_stim_ctrl: applies a framed base vector to a DUT and periodically toggles one bit
// clk, reset (sync active-low); bus.slave: frame_data/frame_valid in,
// dut_inputs/flip_trig/busy/err_index out. Macro FLIP_TRIG_EN enables the flip_trig register.
module flip_stim_ctrl
  import flip_stim_pkg::*;
#(
  parameter int NUM_INS = 8,
  parameter int FRAME_LEN = 24,
  parameter int PERIOD = 10000000
) (
  input logic clk,
  input logic reset,
  flip_stim_ctrl_if.slave bus
);
  localparam int IW = NUM_INS > 1 ? $clog2(NUM_INS) : 1;
  if (FRAME_LEN < IDX_W + NUM_INS) begin : g_len_chk
    $error("FRAME_LEN must be >= 16 + NUM_INS");
  end
  if (PERIOD < 2) begin : g_period_chk
    $error("PERIOD must be >= 2");
  end
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [NUM_INS-1:0] base_q, base_d, dut_q, dut_d;
  logic err_q, err_d;
  logic [IDX_W-1:0] f_idx;
  logic f_ok, cnt_clr, cnt_en, tc, frame_unused;
  assign f_idx = bus.frame_data[IDX_LSB +: IDX_W];
  assign f_ok = f_idx < IDX_W'(NUM_INS);
  assign frame_unused = ^bus.frame_data;
  period_counter #(.PERIOD(PERIOD)) u_cnt (
    .clk(clk), .reset(reset), .clear(cnt_clr), .enable(cnt_en), .tc(tc)
  );
  // The toggle is registered on the WAIT->FLIP edge so dut_inputs changes
  // in the FLIP cycle itself, giving the first toggle at frame+2+PERIOD.
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    base_d = base_q;
    dut_d = dut_q;
    err_d = err_q;
    cnt_clr = 1'b0;
    cnt_en = 1'b0;
    if (bus.frame_valid) begin
      err_d = !f_ok;
      state_d = f_ok ? LOAD : IDLE;
      idx_d = f_ok ? IW'(f_idx) : idx_q;
      base_d = f_ok ? bus.frame_data[VEC_LSB +: NUM_INS] : base_q;
    end else begin
      case (state_q)
        LOAD: begin
          dut_d = base_q;
          cnt_clr = 1'b1;
          state_d = WAIT;
        end
        WAIT: begin
          cnt_en = 1'b1;
          dut_d = tc ? dut_q ^ (NUM_INS'(1) << idx_q) : dut_q;
          state_d = tc ? FLIP : WAIT;
        end
        FLIP: begin
          cnt_clr = 1'b1;
          state_d = WAIT;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      base_q <= '0;
      dut_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      base_q <= base_d;
      dut_q <= dut_d;
      err_q <= err_d;
    end
  end
`ifdef FLIP_TRIG_EN
  logic flip_trig_q, flip_trig_d;
  assign flip_trig_d = !bus.frame_valid && state_q == WAIT && tc;
  always_ff @(posedge clk) flip_trig_q <= reset && flip_trig_d;
  assign bus.flip_trig = flip_trig_q;
`else
  assign bus.flip_trig = 1'b0;
`endif
  assign bus.dut_inputs = dut_q;
  assign bus.busy = state_q != IDLE;
  assign bus.err_index = err_q;
endmodule

// File: tb/tb_flip_stim_ctrl.sv
// tb_flip_stim_ctrl: directed and random frames checked against a timeline model
module tb_flip_stim_ctrl;
  localparam int P = 4;
  logic clk = 1'b0;
  logic reset;
  int checks = 0, passes = 0, cyc = 0, a = 0, idx = 0;
  logic [7:0] base = '0, held = '0;
  bit active = 0, err = 0;
  flip_stim_ctrl_if #(.NUM_INS(8), .FRAME_LEN(28)) bus ();
  flip_stim_ctrl #(.NUM_INS(8), .FRAME_LEN(28), .PERIOD(P)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  // Expected vector: base applied 2 cycles after the frame, indexed bit
  // toggling at frame+2+P and every P+1 cycles after that.
  function automatic logic [7:0] exp_dut();
    int k = cyc - a - 2;
    if (!active || k < 0) return held;
    return (((k + 1) / (P + 1)) % 2 == 1) ? base ^ (8'd1 << idx) : base;
  endfunction
  function automatic logic exp_trig();
`ifdef FLIP_TRIG_EN
    int k = cyc - a - 2;
    return active && k >= 0 && (k + 1) % (P + 1) == 0;
`else
    return 1'b0;
`endif
  endfunction
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
  endtask
  task automatic tick(input logic fv, input logic [27:0] fd, input logic rst);
    logic [7:0] e;
    e = exp_dut();
    check("dut_inputs", bus.dut_inputs, e);
    check("flip_trig", {7'b0, bus.flip_trig}, {7'b0, exp_trig()});
    check("busy", {7'b0, bus.busy}, {7'b0, active});
    check("err_index", {7'b0, bus.err_index}, {7'b0, err});
    bus.frame_valid = fv;
    bus.frame_data = fd;
    reset = rst;
    @(posedge clk);
    #1;
    if (!rst) begin
      active = 0;
      held = '0;
      err = 0;
    end else if (fv) begin
      held = e;
      if (fd[15:0] < 16'd8) begin
        active = 1;
        a = cyc;
        base = fd[23:16];
        idx = int'(fd[15:0]);
        err = 0;
      end else begin
        active = 0;
        err = 1;
      end
    end
    cyc++;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b1);
  endtask
  task automatic frame(input logic [15:0] fi, input logic [7:0] fb);
    tick(1'b1, {4'($urandom), fb, fi}, 1'b1);
  endtask
  initial begin
    logic [27:0] fd;
    reset = 1'b0;
    bus.frame_valid = 1'b0;
    bus.frame_data = '0;
    repeat (2) @(posedge clk);
    #1;
    idle(2);
    frame(16'd3, 8'hA5);
    idle(14);
    frame(16'd9, 8'h33);
    idle(3);
    frame(16'd0, 8'h00);
    idle(14);
    frame(16'd3, 8'hA5);
    idle(3);
    frame(16'd7, 8'h0F);
    idle(13);
    frame(16'd2, 8'h40);
    idle(P);
    tick(1'b0, '0, 1'b0);
    idle(3);
    tick(1'b1, {4'h0, 8'h5A, 16'd1}, 1'b0);
    idle(6);
    frame(16'h0103, 8'hFF);
    idle(3);
    frame(16'd5, 8'hC3);
    idle(2);
    frame(16'h8000, 8'h11);
    idle(3);
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      fd = 28'($urandom);
      fd[15:0] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 9));
      if (r < 8) tick(1'b1, fd, 1'b1);
      else if (r < 10) tick(r[0], fd, 1'b0);
      else tick(1'b0, fd, 1'b1);
    end
    idle(1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
